// File: rtl/noc_local_inject_queue.sv
// Local-port injection FIFO: valid/ready from the packetizer, void/stop toward the router,
// with a head/tail framing checker. One-cycle write-to-output latency; full queue drops flit_ready_out.
module noc_local_inject_queue #(
  parameter int Width = 66,
  parameter int Depth = 4,
  parameter int CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] flit_in,
  input  logic             flit_valid_in,
  output logic             flit_ready_out,
  output logic [Width-1:0] data_p_out,
  output logic             data_void_p_out,
  input  logic             stop_p_in,
  output logic [CntW-1:0]  count_out,
  output logic             frame_err_out,
  input  logic             frame_err_clr
);

  localparam int              PtrW    = $clog2(Depth);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } frame_st_t;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             r_live;
  frame_st_t        r_state;
  logic             r_frame_err;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_head;
  logic w_tail;
  logic w_frame_bad;

  assign w_empty         = (r_count == '0);
  // r_live keeps ready low until the first edge after reset release.
  assign flit_ready_out  = r_live & (r_count < FullCnt);
  assign w_push          = flit_valid_in & flit_ready_out;
  assign w_pop           = ~w_empty & ~stop_p_in;
  assign data_void_p_out = w_empty;
  assign data_p_out      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count_out       = r_count;
  assign frame_err_out   = r_frame_err;

  assign w_head      = flit_in[Width-1];
  assign w_tail      = flit_in[Width-2];
  // A head is legal only outside a packet, a non-head only inside one.
  assign w_frame_bad = (w_head == (r_state == ST_PKT));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= flit_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_frame_err <= 1'b0;
    end else begin
      if (w_push) begin
        if (w_head) begin
          r_state <= w_tail ? ST_IDLE : ST_PKT;
        end else if (r_state == ST_PKT && !w_tail) begin
          r_state <= ST_PKT;
        end else begin
          r_state <= ST_IDLE;
        end
      end
      if (w_push && w_frame_bad) begin
        r_frame_err <= 1'b1;
      end else if (frame_err_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_local_inject_queue.sv
// Scoreboard bench for the local-port injection queue: reset, latency, backpressure,
// streaming push/pop, framing errors and asynchronous reset mid-packet.
module tb_noc_local_inject_queue;

  localparam int W  = 66;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  flit_in = '0;
  logic          flit_valid_in = 1'b0;
  logic          flit_ready_out;
  logic [W-1:0]  data_p_out;
  logic          data_void_p_out;
  logic          stop_p_in = 1'b0;
  logic [CW-1:0] count_out;
  logic          frame_err_out;
  logic          frame_err_clr = 1'b0;

  noc_local_inject_queue #(.Width(W), .Depth(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (flit_in),
    .flit_valid_in  (flit_valid_in),
    .flit_ready_out (flit_ready_out),
    .data_p_out     (data_p_out),
    .data_void_p_out(data_void_p_out),
    .stop_p_in      (stop_p_in),
    .count_out      (count_out),
    .frame_err_out  (frame_err_out),
    .frame_err_clr  (frame_err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input bit h, input bit t, input logic [63:0] p);
    return {h, t, p};
  endfunction

  logic [W-1:0] sb[$];
  bit           m_pkt = 1'b0;
  bit           m_err = 1'b0;
  bit           alive;

  always @(posedge clk or negedge rst) begin
    if (!rst) alive <= 1'b0;
    else      alive <= 1'b1;
  end

  // Decides what the coming edge will do from the stable pre-edge values.
  always @(negedge clk) begin
    logic [W-1:0] e;
    bit           bad;
    bit           acc;
    if (!rst) begin
      sb.delete();
      m_pkt = 1'b0;
      m_err = 1'b0;
    end else begin
      check_eq("ready", W'(flit_ready_out), W'(alive && sb.size() < D));
      check_eq("count", W'(count_out), W'(sb.size()));
      check_eq("void", W'(data_void_p_out), W'(sb.size() == 0));
      check_eq("frame_err", W'(frame_err_out), W'(m_err));
      if (!data_void_p_out && !stop_p_in && sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("data", data_p_out, e);
      end
      acc = flit_valid_in && flit_ready_out;
      bad = 1'b0;
      if (acc) begin
        sb.push_back(flit_in);
        bad = (flit_in[W-1] == m_pkt);
        if (flit_in[W-1]) m_pkt = !flit_in[W-2];
        else              m_pkt = m_pkt && !flit_in[W-2];
      end
      if (acc && bad)          m_err = 1'b1;
      else if (frame_err_clr)  m_err = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] f);
    bit done;
    done = 1'b0;
    flit_in       = f;
    flit_valid_in = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = flit_ready_out;
      step();
    end
    check_eq("send_accept", W'(done), W'(1));
    flit_valid_in = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (count_out == '0 && data_void_p_out) break;
    end
    check_eq("drain", W'(count_out), W'(0));
    step();
  endtask

  initial begin
    // Reset then idle
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_void", W'(data_void_p_out), W'(1));
    check_eq("rst_count", W'(count_out), W'(0));
    check_eq("rst_ready", W'(flit_ready_out), W'(0));
    check_eq("rst_data", data_p_out, W'(0));
    check_eq("rst_err", W'(frame_err_out), W'(0));
    rst = 1'b1;
    step();
    check_eq("post_rst_ready", W'(flit_ready_out), W'(1));
    check_eq("post_rst_void", W'(data_void_p_out), W'(1));

    // Single flit, one-cycle latency
    send(mk(1'b1, 1'b1, 64'h1234));
    check_eq("single_void", W'(data_void_p_out), W'(0));
    check_eq("single_data", data_p_out, mk(1'b1, 1'b1, 64'h1234));
    step();
    check_eq("single_popped", W'(data_void_p_out), W'(1));

    // Fill under stop, fifth flit held until space frees
    stop_p_in = 1'b1;
    for (int i = 0; i < 4; i++) send(mk(1'b1, 1'b1, 64'hA + 64'(i)));
    fork
      send(mk(1'b1, 1'b1, 64'hE));
      begin
        repeat (3) step();
        check_eq("full_count", W'(count_out), W'(4));
        check_eq("full_ready", W'(flit_ready_out), W'(0));
        check_eq("full_hold", data_p_out, mk(1'b1, 1'b1, 64'hA));
        stop_p_in = 1'b0;
      end
    join
    wait_empty();

    // Streaming push and pop at occupancy 2
    stop_p_in = 1'b1;
    send(mk(1'b1, 1'b1, 64'h100));
    send(mk(1'b1, 1'b1, 64'h101));
    stop_p_in = 1'b0;
    for (int i = 0; i < 8; i++) send(mk(1'b1, 1'b1, 64'h200 + 64'(i)));
    check_eq("pp_count", W'(count_out), W'(2));
    wait_empty();

    // Framing errors, clear, and set-over-clear
    send(mk(1'b1, 1'b0, 64'h51));
    send(mk(1'b0, 1'b0, 64'h52));
    check_eq("frm_ok", W'(frame_err_out), W'(0));
    send(mk(1'b1, 1'b0, 64'h53));
    check_eq("frm_dbl_head", W'(frame_err_out), W'(1));
    frame_err_clr = 1'b1;
    step();
    frame_err_clr = 1'b0;
    check_eq("frm_clr", W'(frame_err_out), W'(0));
    send(mk(1'b0, 1'b1, 64'h54));
    check_eq("frm_tail_ok", W'(frame_err_out), W'(0));
    send(mk(1'b0, 1'b0, 64'h55));
    check_eq("frm_body_idle", W'(frame_err_out), W'(1));
    frame_err_clr = 1'b1;
    step();
    frame_err_clr = 1'b0;
    check_eq("frm_clr2", W'(frame_err_out), W'(0));
    frame_err_clr = 1'b1;
    send(mk(1'b0, 1'b1, 64'h57));
    frame_err_clr = 1'b0;
    check_eq("frm_set_wins", W'(frame_err_out), W'(1));
    wait_empty();

    // Asynchronous reset mid-packet
    stop_p_in = 1'b1;
    send(mk(1'b1, 1'b0, 64'h61));
    send(mk(1'b0, 1'b0, 64'h62));
    send(mk(1'b0, 1'b0, 64'h63));
    check_eq("pre_arst_count", W'(count_out), W'(3));
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_void", W'(data_void_p_out), W'(1));
    check_eq("arst_count", W'(count_out), W'(0));
    check_eq("arst_ready", W'(flit_ready_out), W'(0));
    check_eq("arst_data", data_p_out, W'(0));
    check_eq("arst_err", W'(frame_err_out), W'(0));
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    stop_p_in = 1'b0;
    step();
    check_eq("rel_ready", W'(flit_ready_out), W'(1));
    check_eq("rel_void", W'(data_void_p_out), W'(1));
    repeat (4) step();
    send(mk(1'b1, 1'b1, 64'h77));
    check_eq("rel_fsm_idle", W'(frame_err_out), W'(0));
    check_eq("rel_data", data_p_out, mk(1'b1, 1'b1, 64'h77));
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
